// File: rtl/player_ctl.sv
// player_ctl: frame-synchronous controller for the player sprite.
// Latches a direction from the four debounced buttons and moves the sprite
// by STEP pixels once every FRAME_DIV frames. The move is applied only during
// vertical blanking, so the position is stable through active video.
// Optional feature macro: PLAYER_WRAP_EN (horizontal tunnel wrap instead of
// clamping on the x axis; the y axis always clamps).
module player_ctl #(
  parameter int X_INIT    = 497,
  parameter int Y_INIT    = 369,
  parameter int SIZE      = 30,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1,
  parameter int X_MIN     = 6,
  parameter int X_MAX     = 989,
  parameter int Y_MIN     = 6,
  parameter int Y_MAX     = 733
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        game_en,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        sprite_en,
  output logic        frame_tick,
  output logic [1:0]  dir,
  output logic        moving
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [1:0]  DIR_UP    = 2'd0;
  localparam logic [1:0]  DIR_DOWN  = 2'd1;
  localparam logic [1:0]  DIR_LEFT  = 2'd2;
  localparam logic [1:0]  DIR_RIGHT = 2'd3;

  // 12-bit working copies so x+STEP can never wrap around.
  localparam logic [11:0] STEP12    = 12'(STEP);
  localparam logic [11:0] X_MIN12   = 12'(X_MIN);
  localparam logic [11:0] X_MAX12   = 12'(X_MAX);
  localparam logic [11:0] Y_MIN12   = 12'(Y_MIN);
  localparam logic [11:0] Y_MAX12   = 12'(Y_MAX);
  localparam logic [10:0] X_MIN11   = 11'(X_MIN);
  localparam logic [10:0] X_MAX11   = 11'(X_MAX);
  localparam logic [10:0] Y_MIN11   = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX11   = 11'(Y_MAX);
  localparam logic [10:0] X_INIT11  = 11'(X_INIT);
  localparam logic [10:0] Y_INIT11  = 11'(Y_INIT);
  localparam logic [7:0]  DIV_LAST  = 8'(FRAME_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  counter;
  logic [7:0]  counter_nxt;
  logic        vblnk_d;
  logic        vblnk_rise;
  logic [10:0] xpos_nxt;
  logic [10:0] ypos_nxt;
  logic [1:0]  dir_nxt;
  logic        moving_nxt;
  logic [11:0] x_ext;
  logic [11:0] y_ext;
  logic [11:0] x_inc;
  logic [11:0] x_dec;
  logic [11:0] y_inc;
  logic [11:0] y_dec;
  logic        btn_any;

  assign vblnk_rise = vblnk & ~vblnk_d;
  assign btn_any    = btn_up | btn_down | btn_left | btn_right;
  assign x_ext      = {1'b0, xpos};
  assign y_ext      = {1'b0, ypos};
  assign x_inc      = x_ext + STEP12;
  assign x_dec      = x_ext - STEP12;
  assign y_inc      = y_ext + STEP12;
  assign y_dec      = y_ext - STEP12;

  // Next-state logic: frame divider, UPDATE sequencing, game_en override.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    case (state)
      IDLE: begin
        counter_nxt = 8'd0;
        if (game_en) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!game_en) begin
          state_nxt   = IDLE;
          counter_nxt = 8'd0;
        end else if (vblnk_rise) begin
          if (counter == DIV_LAST) begin
            counter_nxt = 8'd0;
            state_nxt   = UPDATE;
          end else begin
            counter_nxt = counter + 8'd1;
            state_nxt   = RUN;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      UPDATE: begin
        if (!game_en) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = 8'd0;
      end
    endcase
  end

  // Direction latch: highest-priority pressed button wins, otherwise hold.
  always_comb begin
    dir_nxt    = dir;
    moving_nxt = moving;
    if (!game_en) begin
      moving_nxt = 1'b0;
    end else if ((state != IDLE) && btn_any) begin
      moving_nxt = 1'b1;
      if (btn_up) begin
        dir_nxt = DIR_UP;
      end else if (btn_down) begin
        dir_nxt = DIR_DOWN;
      end else if (btn_left) begin
        dir_nxt = DIR_LEFT;
      end else begin
        dir_nxt = DIR_RIGHT;
      end
    end else begin
      moving_nxt = moving;
    end
  end

  // Position step: uses the direction latched before this UPDATE cycle.
  always_comb begin
    xpos_nxt = xpos;
    ypos_nxt = ypos;
    if ((state == UPDATE) && game_en && moving) begin
      case (dir)
        DIR_UP: begin
          if (y_ext < (Y_MIN12 + STEP12)) begin
            ypos_nxt = Y_MIN11;
          end else begin
            ypos_nxt = y_dec[10:0];
          end
        end
        DIR_DOWN: begin
          if (y_inc > Y_MAX12) begin
            ypos_nxt = Y_MAX11;
          end else begin
            ypos_nxt = y_inc[10:0];
          end
        end
        DIR_LEFT: begin
          if (x_ext < (X_MIN12 + STEP12)) begin
`ifdef PLAYER_WRAP_EN
            xpos_nxt = X_MAX11;
`else
            xpos_nxt = X_MIN11;
`endif
          end else begin
            xpos_nxt = x_dec[10:0];
          end
        end
        DIR_RIGHT: begin
          if (x_inc > X_MAX12) begin
`ifdef PLAYER_WRAP_EN
            xpos_nxt = X_MIN11;
`else
            xpos_nxt = X_MAX11;
`endif
          end else begin
            xpos_nxt = x_inc[10:0];
          end
        end
        default: begin
          xpos_nxt = xpos;
          ypos_nxt = ypos;
        end
      endcase
    end else begin
      xpos_nxt = xpos;
      ypos_nxt = ypos;
    end
  end

  // State, divider and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= 8'd0;
      vblnk_d    <= 1'b0;
      xpos       <= X_INIT11;
      ypos       <= Y_INIT11;
      dir        <= DIR_UP;
      moving     <= 1'b0;
      sprite_en  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      vblnk_d    <= vblnk;
      xpos       <= xpos_nxt;
      ypos       <= ypos_nxt;
      dir        <= dir_nxt;
      moving     <= moving_nxt;
      sprite_en  <= (state_nxt != IDLE);
      frame_tick <= (state_nxt == UPDATE);
    end
  end

endmodule
